// File: rtl/rpn_token_feeder.sv
// RPN token feeder: buffers host tokens, streams them to the calculator over a
// 4-phase strobe/ack handshake, then captures and acknowledges the result.
module rpn_token_feeder #(
   parameter int DEPTH   = 16,
   parameter int CW      = 5,
   parameter int TIMEOUT = 1024
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          wr_en,
   input  logic [31:0]   wr_data,
   input  logic          wr_is_op,
   input  logic          start,
   output logic [CW-1:0] buf_count,
   output logic          buf_full,
   output logic          busy,
   output logic          calc_input_stb,
   output logic [31:0]   calc_input_data,
   output logic          calc_is_input_operator,
   input  logic          calc_input_ack,
   input  logic          calc_output_stb,
   input  logic [31:0]   calc_output_data,
   output logic          calc_output_ack,
   output logic [31:0]   result_data,
   output logic          result_valid,
   output logic          timeout_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] WAIT_LIMIT = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit TIMEOUT_EN = (TIMEOUT != 0);

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      ACKLOW,
      WAIT_RES,
      RES_ACK
   } state_t;

   state_t r_state;
   state_t w_nextState;

   logic [32:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wrPtr;
   logic [AW-1:0] r_rdPtr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_sent;
   logic [TW-1:0] r_waitCnt;
   logic [31:0]   r_resultData;
   logic          r_resultValid;
   logic          r_timeoutErr;

   logic          w_full;
   logic          w_wrAccept;
   logic          w_startOk;
   logic          w_waitExpired;
   logic          w_timeout;
   logic          w_capture;
   logic          w_tokenDone;
   logic          w_clearBuf;
   logic [32:0]   w_rdToken;

   assign w_full        = (r_count == CW'(DEPTH));
   assign w_wrAccept    = wr_en && (r_state == IDLE) && !w_full;
   // A write landing in the same cycle as start counts toward the sequence.
   assign w_startOk     = start && (r_state == IDLE) && ((r_count != '0) || w_wrAccept);
   assign w_waitExpired = TIMEOUT_EN && (r_state != IDLE) && (r_waitCnt == WAIT_LIMIT);
   assign w_rdToken     = r_mem[r_rdPtr];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_timeout   = 1'b0;
      w_capture   = 1'b0;
      w_tokenDone = 1'b0;
      w_clearBuf  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_startOk) begin
               w_nextState = SEND;
            end
         end
         SEND: begin
            if (calc_input_ack) begin
               w_tokenDone = 1'b1;
               w_nextState = ACKLOW;
            end else if (w_waitExpired) begin
               w_timeout = 1'b1;
            end
         end
         ACKLOW: begin
            if (!calc_input_ack) begin
               w_nextState = (r_sent != r_count) ? SEND : WAIT_RES;
            end else if (w_waitExpired) begin
               w_timeout = 1'b1;
            end
         end
         WAIT_RES: begin
            if (calc_output_stb) begin
               w_capture   = 1'b1;
               w_nextState = RES_ACK;
            end else if (w_waitExpired) begin
               w_timeout = 1'b1;
            end
         end
         RES_ACK: begin
            if (!calc_output_stb) begin
               w_clearBuf  = 1'b1;
               w_nextState = IDLE;
            end else if (w_waitExpired) begin
               w_timeout = 1'b1;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
      if (w_timeout) begin
         w_clearBuf  = 1'b1;
         w_nextState = IDLE;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_wrAccept) begin
         r_mem[r_wrPtr] <= {wr_is_op, wr_data};
      end
   end

   // Pointers, counters and result registers; clearing wins since it only
   // happens outside IDLE where no write can be accepted.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_wrPtr       <= '0;
         r_rdPtr       <= '0;
         r_count       <= '0;
         r_sent        <= '0;
         r_waitCnt     <= '0;
         r_resultData  <= '0;
         r_resultValid <= 1'b0;
         r_timeoutErr  <= 1'b0;
      end else begin
         r_resultValid <= w_capture;
         r_timeoutErr  <= w_timeout;
         if (w_capture) begin
            r_resultData <= calc_output_data;
         end
         if (w_clearBuf) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_sent  <= '0;
         end else begin
            if (w_wrAccept) begin
               r_wrPtr <= r_wrPtr + 1'b1;
               r_count <= r_count + 1'b1;
            end
            if (w_tokenDone) begin
               r_rdPtr <= r_rdPtr + 1'b1;
               r_sent  <= r_sent + 1'b1;
            end
         end
         if (w_nextState != r_state) begin
            r_waitCnt <= '0;
         end else if (r_state != IDLE) begin
            r_waitCnt <= r_waitCnt + 1'b1;
         end
      end
   end

   assign buf_count              = r_count;
   assign buf_full               = w_full;
   assign busy                   = (r_state != IDLE);
   assign calc_input_stb         = (r_state == SEND);
   assign calc_input_data        = calc_input_stb ? w_rdToken[31:0] : '0;
   assign calc_is_input_operator = calc_input_stb ? w_rdToken[32] : 1'b0;
   assign calc_output_ack        = (r_state == RES_ACK);
   assign result_data            = r_resultData;
   assign result_valid           = r_resultValid;
   assign timeout_err            = r_timeoutErr;

endmodule

// File: tb/tb_rpn_token_feeder.sv
// Self-checking bench for rpn_token_feeder: table-driven load checks, a
// calculator model that evaluates received RPN, and randomized runs.
module tb_rpn_token_feeder;

   localparam int DEPTH   = 16;
   localparam int CW      = 5;
   localparam int TIMEOUT = 8;

   typedef struct packed {
      logic        isOp;
      logic [31:0] data;
   } token_t;

   typedef struct packed {
      logic        wrEn;
      logic        isOp;
      logic [31:0] data;
      logic        start;
      logic [4:0]  expCount;
      logic        expFull;
      logic        expBusy;
      logic        expStb;
   } vec_t;

   logic          CLK;
   logic          RST;
   logic          wr_en;
   logic [31:0]   wr_data;
   logic          wr_is_op;
   logic          start;
   logic [CW-1:0] buf_count;
   logic          buf_full;
   logic          busy;
   logic          calc_input_stb;
   logic [31:0]   calc_input_data;
   logic          calc_is_input_operator;
   logic          calc_input_ack;
   logic          calc_output_stb;
   logic [31:0]   calc_output_data;
   logic          calc_output_ack;
   logic [31:0]   result_data;
   logic          result_valid;
   logic          timeout_err;

   int     compareCnt;
   int     mismatchCnt;
   token_t refQ[$];
   vec_t   vecs[7];

   rpn_token_feeder #(
      .DEPTH(DEPTH),
      .CW(CW),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .wr_en(wr_en),
      .wr_data(wr_data),
      .wr_is_op(wr_is_op),
      .start(start),
      .buf_count(buf_count),
      .buf_full(buf_full),
      .busy(busy),
      .calc_input_stb(calc_input_stb),
      .calc_input_data(calc_input_data),
      .calc_is_input_operator(calc_is_input_operator),
      .calc_input_ack(calc_input_ack),
      .calc_output_stb(calc_output_stb),
      .calc_output_data(calc_output_data),
      .calc_output_ack(calc_output_ack),
      .result_data(result_data),
      .result_valid(result_valid),
      .timeout_err(timeout_err)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   // Calculator's arithmetic: op codes 0 add, 1 sub, 2 mul, 3 xor.
   function automatic logic [31:0] evalRpn(input token_t q[$]);
      logic [31:0] st[32];
      int sp;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      sp = 0;
      foreach (q[i]) begin
         if (q[i].isOp) begin
            a = '0;
            b = '0;
            if (sp > 0) begin sp--; b = st[sp]; end
            if (sp > 0) begin sp--; a = st[sp]; end
            case (q[i].data[1:0])
               2'd0:    r = a + b;
               2'd1:    r = a - b;
               2'd2:    r = a * b;
               default: r = a ^ b;
            endcase
            st[sp] = r;
            sp++;
         end else if (sp < 32) begin
            st[sp] = q[i].data;
            sp++;
         end
      end
      return (sp > 0) ? st[sp-1] : 32'd0;
   endfunction

   function automatic vec_t mkVec(input logic wrEn, input logic isOp, input logic [31:0] data,
                                  input logic st, input logic [4:0] cnt, input logic full,
                                  input logic bsy, input logic stb);
      vec_t v;
      v = {wrEn, isOp, data, st, cnt, full, bsy, stb};
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compareCnt++;
      if (actual !== expected) begin
         mismatchCnt++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      wr_en    = v.wrEn;
      wr_is_op = v.isOp;
      wr_data  = v.data;
      start    = v.start;
      if (v.wrEn && refQ.size() < DEPTH) refQ.push_back({v.isOp, v.data});
      @(negedge CLK);
      wr_en = 1'b0;
      start = 1'b0;
   endtask

   task automatic loadToken(input logic isOp, input logic [31:0] data);
      wr_en    = 1'b1;
      wr_is_op = isOp;
      wr_data  = data;
      if (refQ.size() < DEPTH) refQ.push_back({isOp, data});
      @(negedge CLK);
      wr_en = 1'b0;
   endtask

   task automatic startRun();
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic genTokens(input int n);
      int depth;
      depth = 0;
      for (int i = 0; i < n; i++) begin
         if (depth >= 2 && $urandom_range(0, 1) == 1) begin
            loadToken(1'b1, 32'($urandom_range(0, 3)));
            depth--;
         end else begin
            loadToken(1'b0, 32'($urandom_range(0, 1000)));
            depth++;
         end
      end
   endtask

   // Calculator model: accepts refQ.size() tokens, then returns their evaluation.
   task automatic runCalc(input int ackDelay, input int ackHold, input int resDelay,
                          input int resHold, input bit spurious);
      token_t rx[$];
      token_t tok;
      logic [31:0] expRes;
      int n;
      int wt;
      bit ok;
      n = refQ.size();
      expRes = evalRpn(refQ);
      for (int i = 0; i < n; i++) begin
         wt = 0;
         while (!calc_input_stb && wt < 30) begin
            @(negedge CLK);
            wt++;
         end
         if (!calc_input_stb) begin
            checkOutput("stbWait", 32'(calc_input_stb), 32'd1);
            refQ.delete();
            return;
         end
         tok = {calc_is_input_operator, calc_input_data};
         ok = 1'b1;
         for (int d = 0; d < ackDelay; d++) begin
            @(negedge CLK);
            if (!calc_input_stb || {calc_is_input_operator, calc_input_data} != tok) ok = 1'b0;
         end
         checkOutput("stbStable", 32'(ok), 32'd1);
         rx.push_back(tok);
         calc_input_ack = 1'b1;
         if (spurious && i == 0) begin
            calc_output_stb  = 1'b1;
            calc_output_data = 32'hDEAD_BEEF;
         end
         @(negedge CLK);
         checkOutput("stbDropOnAck", 32'(calc_input_stb), 32'd0);
         for (int h = 0; h < ackHold; h++) begin
            @(negedge CLK);
            checkOutput("stbLowWhileAck", 32'(calc_input_stb), 32'd0);
         end
         if (spurious && i == 0) begin
            checkOutput("spuriousIgnored", {30'd0, result_valid, calc_output_ack}, 32'd0);
         end
         calc_input_ack  = 1'b0;
         calc_output_stb = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
         checkOutput("tokData", rx[i].data, refQ[i].data);
         checkOutput("tokIsOp", 32'(rx[i].isOp), 32'(refQ[i].isOp));
      end
      ok = 1'b1;
      for (int d = 0; d <= resDelay; d++) begin
         @(negedge CLK);
         if (calc_input_stb || !busy || result_valid) ok = 1'b0;
      end
      checkOutput("waitResQuiet", 32'(ok), 32'd1);
      calc_output_stb  = 1'b1;
      calc_output_data = evalRpn(rx);
      @(negedge CLK);
      checkOutput("resultValid", 32'(result_valid), 32'd1);
      checkOutput("resultData", result_data, expRes);
      checkOutput("outAckHigh", 32'(calc_output_ack), 32'd1);
      ok = 1'b1;
      for (int h = 0; h < resHold; h++) begin
         @(negedge CLK);
         if (!calc_output_ack || result_valid) ok = 1'b0;
      end
      checkOutput("outAckHeld", 32'(ok), 32'd1);
      calc_output_stb = 1'b0;
      @(negedge CLK);
      checkOutput("outAckDrop", 32'(calc_output_ack), 32'd0);
      checkOutput("busyEnd", 32'(busy), 32'd0);
      checkOutput("countEnd", 32'(buf_count), 32'd0);
      checkOutput("resultHold", result_data, expRes);
      refQ.delete();
   endtask

   initial begin
      int cnt;
      int wt;
      logic [31:0] lastResult;
      compareCnt       = 0;
      mismatchCnt      = 0;
      RST              = 1'b1;
      wr_en            = 1'b0;
      wr_data          = '0;
      wr_is_op         = 1'b0;
      start            = 1'b0;
      calc_input_ack   = 1'b0;
      calc_output_stb  = 1'b0;
      calc_output_data = '0;

      vecs[0] = mkVec(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      vecs[1] = mkVec(1'b0, 1'b0, 32'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      vecs[2] = mkVec(1'b1, 1'b0, 32'd3, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
      vecs[3] = mkVec(1'b1, 1'b0, 32'd4, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0);
      vecs[4] = mkVec(1'b1, 1'b1, 32'd0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
      vecs[5] = mkVec(1'b0, 1'b0, 32'd0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
      vecs[6] = mkVec(1'b0, 1'b0, 32'd0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1);

      repeat (3) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      $display("[TB] reset state");
      checkOutput("rstStb", 32'(calc_input_stb), 32'd0);
      checkOutput("rstInData", calc_input_data, 32'd0);
      checkOutput("rstIsOp", 32'(calc_is_input_operator), 32'd0);
      checkOutput("rstOutAck", 32'(calc_output_ack), 32'd0);
      checkOutput("rstResult", result_data, 32'd0);
      checkOutput("rstValid", 32'(result_valid), 32'd0);
      checkOutput("rstTimeout", 32'(timeout_err), 32'd0);

      $display("[TB] table: load 3 4 ADD, empty start, start");
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput("vecCount", 32'(buf_count), 32'(vecs[i].expCount));
         checkOutput("vecFull", 32'(buf_full), 32'(vecs[i].expFull));
         checkOutput("vecBusy", 32'(busy), 32'(vecs[i].expBusy));
         checkOutput("vecStb", 32'(calc_input_stb), 32'(vecs[i].expStb));
      end
      runCalc(2, 1, 1, 1, 1'b0);
      checkOutput("addResult", result_data, 32'd7);

      $display("[TB] fill to DEPTH and overflow write");
      genTokens(DEPTH);
      loadToken(1'b0, 32'd99);
      checkOutput("fullCount", 32'(buf_count), 32'(DEPTH));
      checkOutput("fullFlag", 32'(buf_full), 32'd1);
      startRun();
      runCalc(1, 0, 0, 0, 1'b0);
      loadToken(1'b0, 32'd12);
      loadToken(1'b0, 32'd30);
      startRun();
      runCalc(0, 1, 1, 0, 1'b0);
      checkOutput("afterWrapResult", result_data, 32'd30);

      $display("[TB] start with same-cycle write");
      loadToken(1'b0, 32'd10);
      wr_en    = 1'b1;
      wr_is_op = 1'b0;
      wr_data  = 32'd20;
      start    = 1'b1;
      refQ.push_back({1'b0, 32'd20});
      @(negedge CLK);
      wr_en = 1'b0;
      start = 1'b0;
      checkOutput("sameCycleCount", 32'(buf_count), 32'd2);
      checkOutput("sameCycleBusy", 32'(busy), 32'd1);
      runCalc(1, 0, 1, 0, 1'b0);

      $display("[TB] writes and start while busy");
      loadToken(1'b0, 32'd5);
      loadToken(1'b0, 32'd6);
      startRun();
      for (int i = 0; i < 3; i++) begin
         wr_en   = 1'b1;
         wr_data = 32'hBAD0 + 32'(i);
         start   = 1'b1;
         @(negedge CLK);
      end
      wr_en = 1'b0;
      start = 1'b0;
      checkOutput("busyWriteCount", 32'(buf_count), 32'd2);
      runCalc(0, 0, 0, 0, 1'b0);

      $display("[TB] timeout with no ack");
      lastResult = result_data;
      loadToken(1'b0, 32'd55);
      startRun();
      cnt = 0;
      wt  = 0;
      while (calc_input_stb && wt < 40) begin
         cnt++;
         @(negedge CLK);
         wt++;
      end
      checkOutput("toStbCycles", 32'(cnt), 32'(TIMEOUT));
      checkOutput("toErrPulse", 32'(timeout_err), 32'd1);
      checkOutput("toCount", 32'(buf_count), 32'd0);
      checkOutput("toBusy", 32'(busy), 32'd0);
      checkOutput("toResultKept", result_data, lastResult);
      @(negedge CLK);
      checkOutput("toErrOnce", 32'(timeout_err), 32'd0);
      refQ.delete();

      $display("[TB] reset during ACKLOW");
      loadToken(1'b0, 32'd8);
      loadToken(1'b0, 32'd9);
      startRun();
      calc_input_ack = 1'b1;
      @(negedge CLK);
      checkOutput("preRstStb", 32'(calc_input_stb), 32'd0);
      RST = 1'b1;
      #1;
      checkOutput("midRstBusy", 32'(busy), 32'd0);
      checkOutput("midRstCount", 32'(buf_count), 32'd0);
      checkOutput("midRstStb", 32'(calc_input_stb), 32'd0);
      checkOutput("midRstResult", result_data, 32'd0);
      calc_input_ack = 1'b0;
      refQ.delete();
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      loadToken(1'b0, 32'd100);
      loadToken(1'b0, 32'd23);
      startRun();
      runCalc(2, 1, 2, 2, 1'b0);

      $display("[TB] randomized runs");
      for (int it = 0; it < 12; it++) begin
         cnt = $urandom_range(1, DEPTH);
         genTokens(cnt);
         checkOutput("randCount", 32'(buf_count), 32'(cnt));
         startRun();
         runCalc($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
      $finish;
   end

endmodule

// File: doc/rpn_token_feeder.md
Name: rpn_token_feeder

Overview:
- Initiator for the calculator's token-input handshake and responder for its result-output handshake.
- A host loads an RPN token sequence (operands and operators) into an internal buffer, then pulses start.
- The block sends the tokens one at a time to the calculator, waits for the calculator's result, acknowledges it and presents it to the host.
- Sits between the host/test controller and the calculator core.

Parameters:
DEPTH, 16, token buffer entries (power of 2, at least 2)
CW, 5, count width; must satisfy 2^CW > DEPTH
TIMEOUT, 1024, max cycles spent in any wait state before abort; 0 disables the timeout

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
wr_en  in  1  host writes a token into the buffer
wr_data  in  32  token value (operand, or operator code)
wr_is_op  in  1  token is an operator
start  in  1  begin sending the buffered sequence
buf_count  out  CW  number of tokens buffered
buf_full  out  1  buf_count == DEPTH
busy  out  1  high in any state other than IDLE
calc_input_stb  out  1  token valid to calculator
calc_input_data  out  32  token value
calc_is_input_operator  out  1  token is an operator
calc_input_ack  in  1  calculator accepted the token
calc_output_stb  in  1  calculator result valid
calc_output_data  in  32  result value
calc_output_ack  out  1  result accepted
result_data  out  32  last captured result; held until the next capture
result_valid  out  1  one-cycle pulse when result_data updates
timeout_err  out  1  one-cycle pulse on abort

Behaviour:
- Reset values (all outputs and state): all outputs 0, buffer pointers 0, FSM in IDLE.
- Reset mid-operation aborts immediately; no handshake completes.
- Buffer writes:
  - Accepted only when wr_en=1, busy=0 and buf_full=0.
  - An accepted write stores {wr_is_op, wr_data} at the write pointer; buf_count increments on the next edge.
  - Writes while full or busy are dropped silently.
- start:
  - Honoured only in IDLE with buf_count > 0; otherwise ignored.
  - If start and an accepted wr_en occur in the same cycle, the write is stored first and the sequence includes it.
- FSM states:
  - IDLE: on a valid start go to SEND. calc_input_stb rises at the edge after start is sampled (1-cycle latency).
  - SEND: calc_input_stb=1, with data and is_op driven from the read pointer and held stable. When calc_input_ack=1 is sampled: drop stb, advance the read pointer, go to ACKLOW.
  - ACKLOW: wait for calc_input_ack=0 (4-phase handshake). Then, if tokens remain, go to SEND (stb re-asserts on the following edge); else go to WAIT_RES.
  - WAIT_RES: on calc_output_stb=1: capture calc_output_data into result_data, pulse result_valid, set calc_output_ack=1, go to RES_ACK.
  - RES_ACK: hold calc_output_ack=1 until calc_output_stb=0 is sampled. Then drop ack, clear the buffer (buf_count=0, pointers 0), go to IDLE.
- Handshake rules:
  - stb is never re-asserted in the same cycle ack is seen high.
  - Exactly one token is transferred per stb/ack pair.
  - A calc_output_stb seen while in SEND or ACKLOW is ignored; results are captured only in WAIT_RES.
- Timeout:
  - A wait counter resets on every state change and counts cycles in SEND, ACKLOW, WAIT_RES and RES_ACK.
  - When the counter reaches TIMEOUT (TIMEOUT ≠ 0): deassert calc_input_stb and calc_output_ack, pulse timeout_err, clear the buffer, go to IDLE.
  - result_data is left unchanged on abort.
- Pointers wrap modulo DEPTH. buf_count is the sole full/empty indicator.

Test Plan:
- Reset with all inputs at 0 → every output 0, busy=0, buf_count=0.
- Write 3,4,op ADD (wr_is_op=1) → buf_count=3. Pulse start; the calculator model acks each token 2 cycles after stb → three 4-phase transfers in order with data 3,4,ADD and is_op 0,0,1. Model returns 7 → result_data=7, result_valid pulses once, calc_output_ack held until stb drops, buf_count=0, busy=0.
- Fill to DEPTH=16, then attempt a 17th write → buf_full=1, count stays 16. Send all 16 → pointers wrap, and the next load/run of 2 tokens transfers correctly.
- Write and start with an empty buffer, plus writes while busy → ignored: no stb, count unchanged.
- TIMEOUT=8 and the calculator never acks → stb high for 8 cycles, then timeout_err pulse, stb=0, buf_count=0, IDLE.
- Assert RST while in ACKLOW, then deassert and reload 2 tokens → outputs 0 immediately on reset; the next sequence runs normally.
